// File: rtl/invmat_arbiter.sv
// rtl/invmat_arbiter.sv - round-robin sharing of one invmat engine with in-order result routing
module invmat_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAT_SIZE     = 5,
    parameter int MAT_DWIDTH   = 46,
    parameter int IMAT_DWIDTH  = 36,
    parameter int MAX_INFLIGHT = 4,
    parameter int TIMEOUT      = 1024,
    localparam int MB = MAT_DWIDTH * MAT_SIZE * MAT_SIZE,
    localparam int OB = IMAT_DWIDTH * MAT_SIZE * MAT_SIZE,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_vld,
    input  logic [NUM_REQ*MB-1:0] req_mat,
    output logic [NUM_REQ-1:0]    req_ack,
    input  logic                  eng_ready,
    output logic                  eng_vld,
    output logic [MB-1:0]         eng_mat,
    input  logic                  eng_out_vld,
    input  logic [OB-1:0]         eng_out,
    input  logic                  eng_error,
    output logic [NUM_REQ-1:0]    rsp_vld,
    output logic [IW-1:0]         rsp_id,
    output logic [OB-1:0]         rsp_mat,
    output logic                  rsp_err,
    input  logic                  clr,
    output logic [CW-1:0]         inflight,
    output logic                  wd_timeout,
    output logic                  spurious,
    output logic [15:0]           issue_cnt
);
    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);
    localparam logic [WW-1:0] WD_PRE = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_INFLIGHT);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic          any_req;
    logic          issue;
    logic          pop;
    logic          full;
    logic [IW-1:0] tags [MAX_INFLIGHT];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] head;
    logic [WW-1:0] wd_cnt;
    logic [MB-1:0] last_mat;
    int            idx;

    // Scan from the highest offset down so the nearest valid index at/after rr_ptr wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (req_vld[idx]) begin
                grant   = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign full     = (count == CNT_FULL);
    assign issue    = any_req & eng_ready & ~full & ~wd_timeout & ~reset;
    assign pop      = eng_out_vld & (count != '0);
    assign head     = tags[rd_ptr];
    assign eng_vld  = issue;
    assign req_ack  = issue ? (NUM_REQ'(1) << grant) : '0;
    assign eng_mat  = issue ? req_mat[int'(grant) * MB +: MB] : last_mat;
    assign inflight = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_mat   <= '0;
            rsp_vld    <= '0;
            rsp_id     <= '0;
            rsp_mat    <= '0;
            rsp_err    <= 1'b0;
            spurious   <= 1'b0;
            issue_cnt  <= '0;
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) tags[i] <= '0;
        end else begin
            if (issue) begin
                rr_ptr       <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                tags[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + 1'b1;
                last_mat     <= req_mat[int'(grant) * MB +: MB];
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rsp_id  <= head;
                rsp_mat <= eng_out;
                rsp_err <= eng_error;
            end
            rsp_vld <= pop ? (NUM_REQ'(1) << head) : '0;

            if (issue && !pop)
                count <= count + 1'b1;
            else if (pop && !issue)
                count <= count - 1'b1;

            if (clr)
                issue_cnt <= '0;
            else if (issue)
                issue_cnt <= issue_cnt + 16'd1;

            // Spurious is judged on the pre-push count, so a same-cycle push does not absorb it.
            if (clr)
                spurious <= 1'b0;
            else if (eng_out_vld && count == '0)
                spurious <= 1'b1;

            if (clr) begin
                wd_cnt     <= '0;
                wd_timeout <= 1'b0;
            end else if (count == '0 || pop) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_PRE)
                    wd_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_invmat_arbiter.sv
// tb/tb_invmat_arbiter.sv - directed self-checking bench for invmat_arbiter
module tb_invmat_arbiter;
    localparam int NR = 4;
    localparam int MS = 2;
    localparam int MD = 46;
    localparam int ID = 36;
    localparam int MI = 4;
    localparam int TO = 16;
    localparam int MB = MD * MS * MS;
    localparam int OB = ID * MS * MS;
    localparam int IW = 2;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_vld = '0;
    logic [NR*MB-1:0]  req_mat;
    logic [NR-1:0]     req_ack;
    logic              eng_ready = 1'b0;
    logic              eng_vld;
    logic [MB-1:0]     eng_mat;
    logic              eng_out_vld = 1'b0;
    logic [OB-1:0]     eng_out = '0;
    logic              eng_error = 1'b0;
    logic [NR-1:0]     rsp_vld;
    logic [IW-1:0]     rsp_id;
    logic [OB-1:0]     rsp_mat;
    logic              rsp_err;
    logic              clr = 1'b0;
    logic [CW-1:0]     inflight;
    logic              wd_timeout;
    logic              spurious;
    logic [15:0]       issue_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_id [4] = '{1, 2, 3, 0};

    invmat_arbiter #(
        .NUM_REQ(NR), .MAT_SIZE(MS), .MAT_DWIDTH(MD), .IMAT_DWIDTH(ID),
        .MAX_INFLIGHT(MI), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .req_vld(req_vld), .req_mat(req_mat), .req_ack(req_ack),
        .eng_ready(eng_ready), .eng_vld(eng_vld), .eng_mat(eng_mat),
        .eng_out_vld(eng_out_vld), .eng_out(eng_out), .eng_error(eng_error),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_mat(rsp_mat), .rsp_err(rsp_err),
        .clr(clr), .inflight(inflight), .wd_timeout(wd_timeout), .spurious(spurious),
        .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [MB-1:0] mat(input int r);
        return (MB'(r + 1) << 120) | MB'(64'h5A00_0000_0000 + 64'(r * 3 + 7));
    endfunction

    function automatic logic [OB-1:0] res(input int k);
        return (OB'(k + 9) << 100) | OB'(64'hC0DE_0000 + 64'(k));
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_vld = '0; eng_ready = 1'b0; eng_out_vld = 1'b0; eng_error = 1'b0; clr = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) req_mat[r*MB +: MB] = mat(r);

        // Reset state
        do_reset;
        reset = 1'b1;
        #1;
        check("rst_eng_vld", 256'(eng_vld), 256'(0));
        check("rst_eng_mat", 256'(eng_mat), 256'(0));
        check("rst_rsp_vld", 256'(rsp_vld), 256'(0));
        check("rst_inflight", 256'(inflight), 256'(0));
        check("rst_issue_cnt", 256'(issue_cnt), 256'(0));
        check("rst_flags", 256'({wd_timeout, spurious, rsp_err}), 256'(0));
        reset = 1'b0;

        // Single requester
        tick;
        req_vld = 4'b0010; eng_ready = 1'b1;
        #1;
        check("single_ack", 256'(req_ack), 256'(4'b0010));
        check("single_eng_vld", 256'(eng_vld), 256'(1));
        check("single_eng_mat", 256'(eng_mat), 256'(mat(1)));
        tick;
        req_vld = '0;
        #1;
        check("single_ack_once", 256'(req_ack), 256'(0));
        check("single_inflight1", 256'(inflight), 256'(1));
        check("single_issue_cnt", 256'(issue_cnt), 256'(1));
        repeat (9) tick;
        eng_out_vld = 1'b1; eng_out = res(1);
        tick;
        eng_out_vld = 1'b0;
        #1;
        check("single_rsp_vld", 256'(rsp_vld), 256'(4'b0010));
        check("single_rsp_id", 256'(rsp_id), 256'(1));
        check("single_rsp_mat", 256'(rsp_mat), 256'(res(1)));
        check("single_rsp_err", 256'(rsp_err), 256'(0));
        check("single_inflight0", 256'(inflight), 256'(0));
        tick;
        check("single_rsp_vld_low", 256'(rsp_vld), 256'(0));
        check("single_rsp_mat_hold", 256'(rsp_mat), 256'(res(1)));

        // Fairness, full, and full plus simultaneous pop
        do_reset;
        req_vld = 4'b1111; eng_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ack", 256'(req_ack), 256'(4'b0001 << k));
            tick;
        end
        #1;
        check("full_inflight", 256'(inflight), 256'(4));
        check("full_no_ack", 256'({eng_vld, req_ack}), 256'(0));
        eng_out_vld = 1'b1; eng_out = res(10);
        #1;
        check("fullpop_no_ack", 256'(req_ack), 256'(0));
        tick;
        eng_out_vld = 1'b0;
        #1;
        check("fullpop_rsp_id", 256'(rsp_id), 256'(0));
        check("fullpop_rsp_vld", 256'(rsp_vld), 256'(4'b0001));
        check("fullpop_inflight3", 256'(inflight), 256'(3));
        check("fullpop_next_ack", 256'(req_ack), 256'(4'b0001));
        tick;
        req_vld = '0;
        #1;
        check("fullpop_inflight4", 256'(inflight), 256'(4));
        check("fullpop_issue_cnt", 256'(issue_cnt), 256'(5));
        for (int k = 0; k < 4; k++) begin
            eng_out_vld = 1'b1; eng_out = res(11 + k);
            tick;
            #1;
            check("order_rsp_id", 256'(rsp_id), 256'(exp_id[k]));
            check("order_rsp_mat", 256'(rsp_mat), 256'(res(11 + k)));
        end
        eng_out_vld = 1'b0;
        tick;
        check("order_drained", 256'(inflight), 256'(0));

        // Backpressure
        do_reset;
        req_vld = 4'b0101; eng_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_blocked", 256'({eng_vld, req_ack}), 256'(0));
            tick;
        end
        eng_ready = 1'b1;
        #1;
        check("bp_ack0", 256'(req_ack), 256'(4'b0001));
        check("bp_mat0", 256'(eng_mat), 256'(mat(0)));
        tick;
        #1;
        check("bp_ack2", 256'(req_ack), 256'(4'b0100));
        tick;
        req_vld = '0;
        #1;
        check("bp_idle", 256'(eng_vld), 256'(0));
        check("bp_mat_hold", 256'(eng_mat), 256'(mat(2)));
        check("bp_inflight", 256'(inflight), 256'(2));

        // Error and spurious
        eng_out_vld = 1'b1; eng_error = 1'b1; eng_out = res(20);
        tick;
        eng_error = 1'b0; eng_out = res(21);
        #1;
        check("err_set", 256'(rsp_err), 256'(1));
        check("err_id", 256'(rsp_id), 256'(0));
        tick;
        eng_out_vld = 1'b0;
        #1;
        check("err_clear", 256'(rsp_err), 256'(0));
        check("err_next_vld", 256'(rsp_vld), 256'(4'b0100));
        eng_out_vld = 1'b1;
        tick;
        eng_out_vld = 1'b0;
        #1;
        check("spur_no_rsp", 256'(rsp_vld), 256'(0));
        check("spur_set", 256'(spurious), 256'(1));
        check("spur_inflight", 256'(inflight), 256'(0));
        clr = 1'b1;
        tick;
        clr = 1'b0;
        #1;
        check("spur_clr", 256'(spurious), 256'(0));

        // Watchdog
        do_reset;
        req_vld = 4'b0001; eng_ready = 1'b1;
        tick;
        req_vld = '0;
        repeat (15) tick;
        check("wd_not_yet", 256'(wd_timeout), 256'(0));
        tick;
        check("wd_fired", 256'(wd_timeout), 256'(1));
        req_vld = 4'b0010;
        #1;
        check("wd_blocks", 256'({eng_vld, req_ack}), 256'(0));
        eng_out_vld = 1'b1; eng_out = res(30);
        tick;
        eng_out_vld = 1'b0;
        #1;
        check("wd_late_rsp", 256'(rsp_vld), 256'(4'b0001));
        check("wd_late_mat", 256'(rsp_mat), 256'(res(30)));
        check("wd_sticky", 256'(wd_timeout), 256'(1));
        clr = 1'b1;
        tick;
        clr = 1'b0;
        #1;
        check("wd_clr", 256'(wd_timeout), 256'(0));
        check("wd_clr_cnt", 256'(issue_cnt), 256'(0));
        check("wd_resume_ack", 256'(req_ack), 256'(4'b0010));
        tick;
        check("wd_resume_cnt", 256'(issue_cnt), 256'(1));
        check("wd_resume_inflight", 256'(inflight), 256'(1));

        // Reset mid-stream
        reset = 1'b1;
        #1;
        check("midrst_ack", 256'({eng_vld, req_ack}), 256'(0));
        check("midrst_inflight", 256'(inflight), 256'(0));
        check("midrst_issue_cnt", 256'(issue_cnt), 256'(0));
        check("midrst_rsp_mat", 256'(rsp_mat), 256'(0));
        tick;
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
